// File: rtl/altera_tse_lvds_rx_aligner.sv
// Receive word aligner for the LVDS SERDES path: finds the 7-bit comma, slips ALTLVDS until
// commas land at bit 0, and forwards data with fixed 2-cycle latency. Stats: ALTERA_TSE_ALIGN_STATS_EN.
module altera_tse_lvds_rx_aligner #(
  parameter int unsigned CDA_PULSE_WIDTH = 2,
  parameter int unsigned SETTLE_CYCLES   = 6,
  parameter int unsigned ACQ_COMMAS      = 3,
  parameter int unsigned LOSS_COMMAS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_locked,
  input  logic [9:0]  rx_data,
  output logic [9:0]  tbi_rx_d,
  output logic        cda_pulse,
  output logic        aligned,
  output logic [3:0]  slip_offset,
  output logic [15:0] align_events,
  output logic [15:0] slip_events
);

  typedef enum logic [2:0] {StHunt, StSlip, StSettle, StCheck, StAligned} state_e;

  localparam logic [3:0] PulseLast  = 4'(CDA_PULSE_WIDTH - 1);
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] AcqTarget  = 8'(ACQ_COMMAS);
  localparam logic [7:0] LossTarget = 8'(LOSS_COMMAS);

  state_e      state_q, state_d;
  logic [9:0]  d1_q, tbi_q;
  logic [3:0]  timer_q, timer_d;
  logic [3:0]  slip_rem_q, slip_rem_d;
  logic [3:0]  slip_offset_q, slip_offset_d;
  logic [7:0]  acq_cnt_q, acq_cnt_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic [19:0] win;
  logic        comma_hit;
  logic [3:0]  comma_pos;

  // Descending scan so the lowest matching position is the one left standing.
  always_comb begin
    win       = {rx_data, d1_q};
    comma_hit = 1'b0;
    comma_pos = '0;
    for (int p = 9; p >= 0; p--) begin
      if (win[p +: 7] == 7'b1111100 || win[p +: 7] == 7'b0000011) begin
        comma_hit = 1'b1;
        comma_pos = 4'(p);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    slip_rem_d    = slip_rem_q;
    slip_offset_d = slip_offset_q;
    acq_cnt_d     = acq_cnt_q;
    loss_cnt_d    = loss_cnt_q;
    if (!rx_locked) begin
      state_d    = StHunt;
      timer_d    = '0;
      slip_rem_d = '0;
      acq_cnt_d  = '0;
      loss_cnt_d = '0;
    end else begin
      case (state_q)
        StHunt: begin
          if (comma_hit && comma_pos == 4'd0) begin
            acq_cnt_d = 8'd1;
            state_d   = (AcqTarget <= 8'd1) ? StAligned : StCheck;
          end else if (comma_hit) begin
            slip_rem_d    = comma_pos;
            slip_offset_d = comma_pos;
            timer_d       = '0;
            state_d       = StSlip;
          end
        end
        StSlip: begin
          if (timer_q == PulseLast) begin
            timer_d    = '0;
            slip_rem_d = slip_rem_q - 4'd1;
            state_d    = StSettle;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        StSettle: begin
          if (timer_q == SettleLast) begin
            timer_d = '0;
            state_d = (slip_rem_q != 4'd0) ? StSlip : StHunt;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        StCheck: begin
          if (comma_hit && comma_pos == 4'd0) begin
            if (acq_cnt_q + 8'd1 >= AcqTarget) begin
              acq_cnt_d = '0;
              state_d   = StAligned;
            end else begin
              acq_cnt_d = acq_cnt_q + 8'd1;
            end
          end else if (comma_hit) begin
            acq_cnt_d     = '0;
            slip_offset_d = comma_pos;
            state_d       = StHunt;
          end
        end
        StAligned: begin
          if (comma_hit && comma_pos == 4'd0) begin
            loss_cnt_d = '0;
          end else if (comma_hit) begin
            slip_offset_d = comma_pos;
            if (loss_cnt_q + 8'd1 >= LossTarget) begin
              loss_cnt_d = '0;
              state_d    = StHunt;
            end else begin
              loss_cnt_d = loss_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHunt;
      d1_q          <= '0;
      tbi_q         <= '0;
      timer_q       <= '0;
      slip_rem_q    <= '0;
      slip_offset_q <= '0;
      acq_cnt_q     <= '0;
      loss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      d1_q          <= rx_data;
      tbi_q         <= d1_q;
      timer_q       <= timer_d;
      slip_rem_q    <= slip_rem_d;
      slip_offset_q <= slip_offset_d;
      acq_cnt_q     <= acq_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
    end
  end

  assign tbi_rx_d    = tbi_q;
  assign cda_pulse   = (state_q == StSlip);
  assign aligned     = (state_q == StAligned);
  assign slip_offset = slip_offset_q;

`ifdef ALTERA_TSE_ALIGN_STATS_EN
  logic [15:0] align_events_q, slip_events_q;

  // Entering SLIP is exactly the cycle cda_pulse rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      align_events_q <= '0;
      slip_events_q  <= '0;
    end else begin
      if (state_q != StAligned && state_d == StAligned && align_events_q != 16'hFFFF) begin
        align_events_q <= align_events_q + 16'd1;
      end
      if (state_q != StSlip && state_d == StSlip && slip_events_q != 16'hFFFF) begin
        slip_events_q <= slip_events_q + 16'd1;
      end
    end
  end

  assign align_events = align_events_q;
  assign slip_events  = slip_events_q;
`else
  assign align_events = 16'h0000;
  assign slip_events  = 16'h0000;
`endif

endmodule

// File: tb/tb_altera_tse_lvds_rx_aligner.sv
// Bench for the LVDS word aligner: serial /I2/ stream with an emulated ALTLVDS bit slip,
// checked every cycle against a behavioural model of the alignment rules.
module tb_altera_tse_lvds_rx_aligner;
  localparam int PW = 2, SC = 6, ACQ = 3, LOSS = 2;
  localparam int MHunt = 0, MSlip = 1, MSettle = 2, MCheck = 3, MAligned = 4;

  logic        clk = 1'b0;
  logic        reset, rx_locked;
  logic [9:0]  rx_data;
  logic [9:0]  tbi_rx_d;
  logic        cda_pulse, aligned;
  logic [3:0]  slip_offset;
  logic [15:0] align_events, slip_events;

  always #5 clk = ~clk;

  altera_tse_lvds_rx_aligner #(
    .CDA_PULSE_WIDTH(PW), .SETTLE_CYCLES(SC), .ACQ_COMMAS(ACQ), .LOSS_COMMAS(LOSS)
  ) dut (
    .clk(clk), .reset(reset), .rx_locked(rx_locked), .rx_data(rx_data),
    .tbi_rx_d(tbi_rx_d), .cda_pulse(cda_pulse), .aligned(aligned),
    .slip_offset(slip_offset), .align_events(align_events), .slip_events(slip_events)
  );

  int n_cmp = 0, n_err = 0;
  bit sim_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Earliest serial position of a comma in a 20-bit window (bit 0 first on the wire), or -1.
  function automatic int comma_at(input logic [19:0] w);
    int plus_seq[7]  = '{0, 0, 1, 1, 1, 1, 1};
    int minus_seq[7] = '{1, 1, 0, 0, 0, 0, 0};
    for (int p = 0; p < 10; p++) begin
      bit mp = 1, mm = 1;
      for (int k = 0; k < 7; k++) begin
        if (int'(w[p + k]) != plus_seq[k])  mp = 0;
        if (int'(w[p + k]) != minus_seq[k]) mm = 0;
      end
      if (mp || mm) return p;
    end
    return -1;
  endfunction

  // Periodic /I2/ ordered set: K28.5(RD-) then D16.2(RD+), 20 serial bits.
  function automatic logic [9:0] word_at(input int b);
    logic [19:0] pat;
    logic [9:0]  w;
    pat = {10'h289, 10'h17C};
    for (int i = 0; i < 10; i++) w[i] = pat[(b + i) % 20];
    return w;
  endfunction

  // Behavioural model state
  int         m_mode, m_left, m_slips, m_acq, m_loss, m_off, m_align_ev, m_slip_ev;
  logic [9:0] m_d1, m_tbi;

  task automatic model_step(input logic rst, input logic lock, input logic [9:0] din);
    int p;
    if (rst) begin
      m_mode = MHunt; m_left = 0; m_slips = 0; m_acq = 0; m_loss = 0; m_off = 0;
      m_align_ev = 0; m_slip_ev = 0; m_d1 = '0; m_tbi = '0;
      return;
    end
    p = comma_at({din, m_d1});
    m_tbi = m_d1;
    m_d1  = din;
    if (!lock) begin
      m_mode = MHunt; m_left = 0; m_slips = 0; m_acq = 0; m_loss = 0;
      return;
    end
    case (m_mode)
      MHunt: begin
        if (p == 0) begin
          m_acq = 1;
          if (m_acq >= ACQ) begin m_mode = MAligned; m_acq = 0; if (m_align_ev < 65535) m_align_ev++; end
          else m_mode = MCheck;
        end else if (p > 0) begin
          m_slips = p; m_off = p; m_mode = MSlip; m_left = PW;
          if (m_slip_ev < 65535) m_slip_ev++;
        end
      end
      MSlip: begin
        m_left--;
        if (m_left == 0) begin m_slips--; m_mode = MSettle; m_left = SC; end
      end
      MSettle: begin
        m_left--;
        if (m_left == 0) begin
          if (m_slips > 0) begin
            m_mode = MSlip; m_left = PW;
            if (m_slip_ev < 65535) m_slip_ev++;
          end else m_mode = MHunt;
        end
      end
      MCheck: begin
        if (p == 0) begin
          m_acq++;
          if (m_acq >= ACQ) begin m_mode = MAligned; m_acq = 0; if (m_align_ev < 65535) m_align_ev++; end
        end else if (p > 0) begin
          m_mode = MHunt; m_acq = 0; m_off = p;
        end
      end
      default: begin
        if (p == 0) m_loss = 0;
        else if (p > 0) begin
          m_off = p; m_loss++;
          if (m_loss >= LOSS) begin m_mode = MHunt; m_loss = 0; end
        end
      end
    endcase
  endtask

  initial begin : compare
    forever begin
      @(posedge clk);
      model_step(reset, rx_locked, rx_data);
      #1;
      if (!sim_done) begin
        check("tbi_rx_d", 32'(tbi_rx_d), 32'(m_tbi));
        check("cda_pulse", 32'(cda_pulse), 32'(m_mode == MSlip));
        check("aligned", 32'(aligned), 32'(m_mode == MAligned));
        check("slip_offset", 32'(slip_offset), 32'(m_off));
`ifdef ALTERA_TSE_ALIGN_STATS_EN
        check("align_events", 32'(align_events), 32'(m_align_ev));
        check("slip_events", 32'(slip_events), 32'(m_slip_ev));
`else
        check("align_events", 32'(align_events), 32'h0);
        check("slip_events", 32'(slip_events), 32'h0);
`endif
      end
    end
  end

  // Stimulus-side ALTLVDS emulation: each cda_pulse rising edge skips one serial bit.
  int bp = 1000, rises = 0, highs = 0;
  bit cda_prev = 0, rand_data = 0;

  task automatic tick();
    @(negedge clk);
    if (cda_pulse && !cda_prev) begin bp++; rises++; end
    if (cda_pulse) highs++;
    cda_prev = cda_pulse;
    rx_data  = rand_data ? 10'($urandom) : word_at(bp);
    bp += 10;
  endtask

  task automatic set_off(input int k);
    bp = bp - (bp % 10) + k;
  endtask

  task automatic wait_aligned(input string name, input logic want, input int budget);
    int n = 0;
    while (aligned !== want && n < budget) begin tick(); n++; end
    check(name, 32'(aligned), 32'(want));
  endtask

  initial begin : stim
    logic [9:0] w0;
    int s_al, s_sl;
    bit dropped;
    reset = 1'b1; rx_locked = 1'b0; rx_data = word_at(bp);

    check("model_comma_p0", 32'(comma_at({10'h289, 10'h17C})), 32'd0);
    check("model_comma_p4", 32'(comma_at({word_at(1026), word_at(1016)})), 32'd4);

    repeat (3) tick();
    check("reset_tbi", 32'(tbi_rx_d), 32'h0);
    check("reset_cda", 32'(cda_pulse), 32'h0);
    check("reset_aligned", 32'(aligned), 32'h0);
    check("reset_offset", 32'(slip_offset), 32'h0);

    // Unlocked with a clean comma stream: nothing happens.
    reset = 1'b0;
    highs = 0;
    repeat (20) tick();
    check("unlocked_no_pulse", 32'(highs), 32'd0);
    check("unlocked_not_aligned", 32'(aligned), 32'd0);

    // Already at offset 0.
    rx_locked = 1'b1; rises = 0;
    wait_aligned("acq_offset0", 1'b1, 60);
    check("offset0_no_slip", 32'(rises), 32'd0);
    w0 = rx_data;
    tick(); tick();
    check("latency_2", 32'(tbi_rx_d), 32'(w0));

    // Comma at offset 4.
    rx_locked = 1'b0; tick(); tick();
    s_al = align_events; s_sl = slip_events;
    set_off(6); rx_locked = 1'b1; rises = 0; highs = 0;
    wait_aligned("acq_offset4", 1'b1, 300);
    check("offset4_bursts", 32'(rises), 32'd4);
    check("offset4_high_cycles", 32'(highs), 32'd8);
    check("offset4_slip_offset", 32'(slip_offset), 32'd4);
`ifdef ALTERA_TSE_ALIGN_STATS_EN
    check("offset4_slip_events", 32'(slip_events - 16'(s_sl)), 32'd4);
    check("offset4_align_events", 32'(align_events - 16'(s_al)), 32'd1);
`endif

    // Shift stream while aligned: comma now at 3.
    bp -= 3; rises = 0;
    wait_aligned("shift3_drop", 1'b0, 60);
    wait_aligned("shift3_reacq", 1'b1, 300);
    check("shift3_bursts", 32'(rises), 32'd3);
    check("shift3_offset", 32'(slip_offset), 32'd3);

    // Drop lock during the second slip.
    bp -= 4; rises = 0;
    begin
      int n = 0;
      while (rises < 2 && n < 300) begin tick(); n++; end
    end
    check("second_slip_seen", 32'(rises), 32'd2);
    rx_locked = 1'b0;
    @(posedge clk); #1;
    check("unlock_truncates", 32'(cda_pulse), 32'd0);
    repeat (5) tick();
    rx_locked = 1'b1; rises = 0;
    wait_aligned("relock_reacq", 1'b1, 300);
    check("relock_bursts", 32'(rises), 32'd2);

    // Reset in the middle of a slip.
    set_off(5); rises = 0;
    begin
      int n = 0;
      while (rises < 1 && n < 300) begin tick(); n++; end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midslip_reset_cda", 32'(cda_pulse), 32'd0);
    check("midslip_reset_offset", 32'(slip_offset), 32'd0);
    tick(); reset = 1'b0;

    // Randomized offsets, lock glitches and reset pulses.
    for (int it = 0; it < 8; it++) begin
      bp += int'($urandom_range(1, 9));
      for (int c = 0; c < 150; c++) begin
        rx_locked = ($urandom_range(0, 199) != 0);
        reset     = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    reset = 1'b0; rx_locked = 1'b1;
    rand_data = 1;
    repeat (200) tick();
    rand_data = 0;
    repeat (10) tick();

`ifdef ALTERA_TSE_ALIGN_STATS_EN
    // Saturation of the slip counter.
    rx_locked = 1'b0; tick(); tick();
    @(negedge clk);
    force dut.slip_events_q = 16'hFFFE;
    m_slip_ev = 16'hFFFE;
    @(negedge clk);
    release dut.slip_events_q;
    set_off(7); rx_locked = 1'b1;
    wait_aligned("sat_reacq", 1'b1, 300);
    check("slip_events_sat", 32'(slip_events), 32'hFFFF);
`endif

    dropped = 0;
    sim_done = 1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
